// File: rtl/ccu_nibble_cipher.sv
// Nibble-serial iterative block cipher: substitution/rotation rounds with a rolling key schedule.
// Latency: last input beat to first out_valid is ROUNDS+1 cycles (encrypt), 2*ROUNDS+1 (decrypt).
// Backpressure: in_ready only in LOAD; in OUT the result nibble holds until out_ready accepts it.
module ccu_nibble_cipher #(
  parameter int NIBBLES = 4,
  parameter int ROUNDS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  input  logic [3:0] kin,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode,
  output logic [3:0] dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);
  localparam logic [3:0]    LAST_RND = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {LOAD, KEXP, ROUND, WHITEN, OUT} state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Nibble i moves to nibble i+1; the top nibble wraps into nibble 0.
  function automatic logic [W-1:0] rot_l(input logic [W-1:0] v);
    return {v[W-5:0], v[W-1:W-4]};
  endfunction

  function automatic logic [W-1:0] rot_r(input logic [W-1:0] v);
    return {v[3:0], v[W-1:4]};
  endfunction

  function automatic logic [W-1:0] sub_all(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < NIBBLES; i++) r[4*i +: 4] = sbox(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] inv_all(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < NIBBLES; i++) r[4*i +: 4] = sbox_inv(v[4*i +: 4]);
    return r;
  endfunction

  // K(r) -> K(r+1): rotate, then fold the 4-bit round constant r+1 into nibble 0.
  function automatic logic [W-1:0] key_fwd(input logic [W-1:0] k, input logic [3:0] r);
    logic [W-1:0] t;
    t = rot_l(k);
    t[3:0] = t[3:0] ^ (r + 4'd1);
    return t;
  endfunction

  // K(r+1) -> K(r): exact inverse of key_fwd.
  function automatic logic [W-1:0] key_bwd(input logic [W-1:0] k, input logic [3:0] r);
    logic [W-1:0] t;
    t = k;
    t[3:0] = t[3:0] ^ (r + 4'd1);
    return rot_r(t);
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    rnd, rnd_n;
  logic          dec, dec_n;
  logic [W-1:0]  s, s_n, k, k_n;
  logic [W-1:0]  k_next, k_prev;

  assign k_next = key_fwd(k, rnd);
  assign k_prev = key_bwd(k, rnd);

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign out_valid = (state == OUT);
  assign dout      = (state == OUT) ? s[4*cnt +: 4] : 4'h0;

  // State register; reset discards any partial block immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      rnd   <= '0;
      dec   <= 1'b0;
      s     <= '0;
      k     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rnd   <= rnd_n;
      dec   <= dec_n;
      s     <= s_n;
      k     <= k_n;
    end
  end

  // Next-state and datapath: load, key expansion, rounds, whitening, drain.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rnd_n   = rnd;
    dec_n   = dec;
    s_n     = s;
    k_n     = k;
    unique case (state)
      LOAD: begin
        if (in_valid) begin
          s_n[4*cnt +: 4] = din;
          k_n[4*cnt +: 4] = kin;
          if (cnt == '0) dec_n = mode;
          if (cnt == LAST_NIB) begin
            cnt_n   = '0;
            state_n = dec ? KEXP : ROUND;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      KEXP: begin
        k_n = k_next;
        // rnd is left at ROUNDS-1 so the decrypt rounds can count down from it.
        if (rnd == LAST_RND) state_n = WHITEN;
        else                 rnd_n   = rnd + 4'd1;
      end
      ROUND: begin
        if (!dec) begin
          s_n = rot_l(sub_all(s ^ k));
          k_n = k_next;
          if (rnd == LAST_RND) begin
            rnd_n   = '0;
            state_n = WHITEN;
          end else begin
            rnd_n = rnd + 4'd1;
          end
        end else begin
          s_n = inv_all(rot_r(s)) ^ k_prev;
          k_n = k_prev;
          if (rnd == '0) state_n = OUT;
          else           rnd_n   = rnd - 4'd1;
        end
      end
      WHITEN: begin
        s_n     = s ^ k;
        state_n = dec ? ROUND : OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (cnt == LAST_NIB) begin
            cnt_n   = '0;
            state_n = LOAD;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: state_n = LOAD;
    endcase
  end

endmodule

// File: tb/tb_ccu_nibble_cipher.sv
// Scoreboard bench for ccu_nibble_cipher: a default instance and a ROUNDS=1 instance.
// Expected nibbles come from an array-based reference model and are queued at issue time.
// A negedge monitor pops and compares on every output handshake and checks stall stability.
module tb_ccu_nibble_cipher;

  localparam int N  = 4;
  localparam int R0 = 4;
  localparam int R1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [3:0]       din [2];
  logic [3:0]       kin [2];
  logic [1:0]       in_valid, mode, out_ready;
  logic [1:0]       in_ready, out_valid, busy;
  logic [1:0][3:0]  dout;

  ccu_nibble_cipher #(.NIBBLES(N), .ROUNDS(R0)) u_def (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .kin(kin[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .mode(mode[0]), .dout(dout[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .busy(busy[0])
  );

  ccu_nibble_cipher #(.NIBBLES(N), .ROUNDS(R1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .kin(kin[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .mode(mode[1]), .dout(dout[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .busy(busy[1])
  );

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  logic [3:0] exp_q[$];

  int sbox_tab[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  int inv_tab[16]  = '{5, 14, 15, 8, 12, 1, 2, 13, 11, 4, 6, 3, 0, 7, 9, 10};

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: full key schedule precomputed forward, then rounds on nibble arrays.
  function automatic logic [15:0] ref_cipher(input logic [15:0] blk, input logic [15:0] key,
                                             input bit decrypt, input int rounds);
    int s[N];
    int t[N];
    int ks[16][N];
    logic [15:0] res;
    for (int i = 0; i < N; i++) begin
      s[i]     = int'(blk[4*i +: 4]);
      ks[0][i] = int'(key[4*i +: 4]);
    end
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < N; i++) ks[r+1][(i+1)%N] = ks[r][i];
      ks[r+1][0] = ks[r+1][0] ^ ((r + 1) % 16);
    end
    if (!decrypt) begin
      for (int r = 0; r < rounds; r++) begin
        for (int i = 0; i < N; i++) t[(i+1)%N] = sbox_tab[s[i] ^ ks[r][i]];
        s = t;
      end
      for (int i = 0; i < N; i++) s[i] = s[i] ^ ks[rounds][i];
    end else begin
      for (int i = 0; i < N; i++) s[i] = s[i] ^ ks[rounds][i];
      for (int r = rounds - 1; r >= 0; r--) begin
        for (int i = 0; i < N; i++) t[i] = inv_tab[s[(i+1)%N]] ^ ks[r][i];
        s = t;
      end
    end
    for (int i = 0; i < N; i++) res[4*i +: 4] = 4'(s[i]);
    return res;
  endfunction

  // One input beat; called just after a rising edge, returns just after the accepting edge.
  task automatic put_beat(input int sel, input logic [3:0] d, input logic [3:0] k, input logic m);
    int g;
    din[sel] = d;
    kin[sel] = k;
    mode[sel] = m;
    in_valid[sel] = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready[sel] && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("load_in_ready", int'(in_ready[sel]), 1);
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
  endtask

  task automatic send_block(input int sel, input logic [15:0] blk, input logic [15:0] key,
                            input bit decrypt, input int max_gap, input bit flip_mode,
                            input logic [15:0] want);
    int g;
    for (int i = 0; i < N; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        din[sel] = 4'($urandom);
        mode[sel] = 1'($urandom);
        @(posedge clk);
        #1;
      end
      put_beat(sel, blk[4*i +: 4], key[4*i +: 4],
               (i == 0 || !flip_mode) ? decrypt : ~decrypt);
    end
    for (int i = 0; i < N; i++) exp_q.push_back(want[4*i +: 4]);
  endtask

  // Cycles from the accepting edge of the last beat to the first out_valid.
  task automatic check_latency(input int sel, input int want, input string name);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!out_valid[sel] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check(name, lat, want);
  endtask

  task automatic wait_idle(input int sel);
    int g;
    g = 0;
    @(negedge clk);
    while (busy[sel] && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("return_to_load", int'(busy[sel]), 0);
    check("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: output handshakes against the scoreboard, stall stability, in_ready while draining.
  logic [1:0]      stall_prev = '0;
  logic [1:0][3:0] dout_prev  = '0;
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (stall_prev[s] && rst_n) begin
        check("stall_out_valid", int'(out_valid[s]), 1);
        check("stall_dout", int'(dout[s]), int'(dout_prev[s]));
      end
      if (out_valid[s]) check("in_ready_in_out", int'(in_ready[s]), 0);
      if (out_valid[s] && out_ready[s]) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h, expected no output (t=%0t)", dout[s], $time);
        end else begin
          check("dout", int'(dout[s]), int'(exp_q.pop_front()));
        end
      end
      stall_prev[s] = out_valid[s] && !out_ready[s];
      dout_prev[s]  = dout[s];
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] blk, key, ct, want;
    bit          md;
    int          x0;

    rst_n = 1'b0;
    in_valid = '0;
    mode = '0;
    out_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0;
      kin[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_in_ready", int'(in_ready[i]), 1);
      check("reset_out_valid", int'(out_valid[i]), 0);
      check("reset_dout", int'(dout[i]), 0);
      check("reset_busy", int'(busy[i]), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ROUNDS=1 known-answer vectors.
    send_block(1, 16'h0000, 16'h0000, 1'b0, 0, 1'b0, 16'hCCCD);
    check_latency(1, 2, "latency_enc_r1");
    wait_idle(1);
    send_block(1, 16'hCCCD, 16'h0000, 1'b1, 0, 1'b0, 16'h0000);
    check_latency(1, 3, "latency_dec_r1");
    wait_idle(1);

    // Random encrypt/decrypt round trips on the default core.
    for (int n = 0; n < 200; n++) begin
      blk = 16'($urandom);
      key = 16'($urandom);
      ct  = ref_cipher(blk, key, 1'b0, R0);
      send_block(0, blk, key, 1'b0, 0, 1'b0, ct);
      check_latency(0, R0 + 1, "latency_enc");
      wait_idle(0);
      send_block(0, ct, key, 1'b1, 0, 1'b0, blk);
      check_latency(0, 2 * R0 + 1, "latency_dec");
      wait_idle(0);
    end

    // A few random blocks through the ROUNDS=1 core in both directions.
    for (int n = 0; n < 20; n++) begin
      blk = 16'($urandom);
      key = 16'($urandom);
      md  = 1'($urandom);
      send_block(1, blk, key, md, 0, 1'b0, ref_cipher(blk, key, md, R1));
      check_latency(1, md ? 3 : 2, "latency_r1_random");
      wait_idle(1);
    end

    // Backpressure: 5 stalled cycles, then out_ready every other cycle.
    blk = 16'($urandom);
    key = 16'($urandom);
    out_ready[0] = 1'b0;
    send_block(0, blk, key, 1'b0, 0, 1'b0, ref_cipher(blk, key, 1'b0, R0));
    check_latency(0, R0 + 1, "latency_backpressure");
    x0 = xfer_cnt;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      out_ready[0] = (c % 2 == 0);
    end
    out_ready[0] = 1'b1;
    wait_idle(0);
    check("backpressure_transfers", xfer_cnt - x0, N);

    // Gaps in in_valid, mode flipping after beat 0, and garbage inputs while busy.
    for (int n = 0; n < 12; n++) begin
      blk  = 16'($urandom);
      key  = 16'($urandom);
      md   = 1'($urandom);
      want = ref_cipher(blk, key, md, R0);
      send_block(0, blk, key, md, 3, 1'b1, want);
      in_valid[0] = 1'b1;
      din[0] = 4'($urandom);
      kin[0] = 4'($urandom);
      mode[0] = ~md;
      check_latency(0, md ? 2 * R0 + 1 : R0 + 1, "latency_gapped");
      in_valid[0] = 1'b0;
      wait_idle(0);
    end

    // Reset during ROUND.
    blk = 16'($urandom);
    key = 16'($urandom);
    send_block(0, blk, key, 1'b0, 0, 1'b0, ref_cipher(blk, key, 1'b0, R0));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_round_busy", int'(busy[0]), 0);
    check("abort_round_in_ready", int'(in_ready[0]), 1);
    check("abort_round_out_valid", int'(out_valid[0]), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset while a stalled result is presented.
    out_ready[0] = 1'b0;
    blk = 16'($urandom);
    send_block(0, blk, key, 1'b0, 0, 1'b0, ref_cipher(blk, key, 1'b0, R0));
    check_latency(0, R0 + 1, "latency_before_abort");
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid_async", int'(out_valid[0]), 0);
    check("abort_dout_async", int'(dout[0]), 0);
    exp_q.delete();
    out_ready[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fresh blocks after the aborts must carry no residue.
    for (int n = 0; n < 2; n++) begin
      blk = 16'($urandom);
      key = 16'($urandom);
      md  = (n == 1);
      send_block(0, blk, key, md, 0, 1'b0, ref_cipher(blk, key, md, R0));
      check_latency(0, md ? 2 * R0 + 1 : R0 + 1, "latency_after_abort");
      wait_idle(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
